// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths, write-back entry type and SP reset value
package regfile_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int NUM_REGS = 32;
   localparam logic [31:0] SP_RESET = 32'h00000600;
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: MDU write-back FIFO exposing per-entry valid/register fields for busy decode
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic [REG_ADDR_W-1:0]   push_reg,
   input  logic [DW-1:0]           push_data,
   input  logic                    pop,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic [REG_ADDR_W-1:0]   head_reg,
   output logic [DW-1:0]           head_data,
   output logic [DEPTH-1:0]        ent_valid,
   output logic [REG_ADDR_W-1:0]   ent_reg [DEPTH]
);
   logic [$clog2(DEPTH)-1:0] wr_ptr, rd_ptr;
   logic [DW-1:0] ent_data [DEPTH];

   assign full      = count == ($clog2(DEPTH)+1)'(DEPTH);
   assign empty     = count == '0;
   assign head_reg  = ent_reg[rd_ptr];
   assign head_data = ent_data[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         ent_valid <= '0;
      end else begin
         if (push) begin
            wr_ptr            <= wr_ptr + 1'b1;
            ent_valid[wr_ptr] <= 1'b1;
         end
         if (pop) begin
            rd_ptr            <= rd_ptr + 1'b1;
            ent_valid[rd_ptr] <= 1'b0;
         end
         count <= count + ($clog2(DEPTH)+1)'(push) - ($clog2(DEPTH)+1)'(pop);
      end
   end

   // payload needs no reset; ent_valid gates every use of it
   always_ff @(posedge clk) begin
      if (push) begin
         ent_reg[wr_ptr]  <= push_reg;
         ent_data[wr_ptr] <= push_data;
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges pipeline WB (priority) and queued MDU writes onto the register-file write port
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = regfile_pkg::DATA_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_wb_valid,
   input  logic [REG_ADDR_W-1:0]   i_wb_reg,
   input  logic [DATA_W-1:0]       i_wb_data,
   input  logic                    i_mdu_valid,
   input  logic [REG_ADDR_W-1:0]   i_mdu_reg,
   input  logic [DATA_W-1:0]       i_mdu_data,
   output logic                    o_mdu_ready,
   output logic                    o_reg_write,
   output logic [REG_ADDR_W-1:0]   o_write_register,
   output logic [DATA_W-1:0]       o_write_data,
   output logic [NUM_REGS-1:0]     o_busy,
   output logic [$clog2(DEPTH):0]  o_count
);
   logic                  wb_req, push, pop, full, empty;
   logic [REG_ADDR_W-1:0] head_reg;
   logic [DATA_W-1:0]     head_data;
   logic [DEPTH-1:0]      ent_valid;
   logic [REG_ADDR_W-1:0] ent_reg [DEPTH];

   // writes to r0 are architecturally void: neither a WB request nor a queued entry
   assign wb_req      = i_wb_valid && i_wb_reg != '0;
   assign o_mdu_ready = !reset && !full;
   assign push        = i_mdu_valid && o_mdu_ready && i_mdu_reg != '0;
   assign pop         = !wb_req && !empty;

   wb_fifo #(.DEPTH(DEPTH), .DW(DATA_W)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_reg  (i_mdu_reg),
      .push_data (i_mdu_data),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .count     (o_count),
      .head_reg  (head_reg),
      .head_data (head_data),
      .ent_valid (ent_valid),
      .ent_reg   (ent_reg)
   );

   always_comb begin
      o_busy = '0;
      for (int i = 0; i < DEPTH; i++)
         if (ent_valid[i]) o_busy[ent_reg[i]] = 1'b1;
      o_busy[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_reg_write      <= 1'b0;
         o_write_register <= '0;
         o_write_data     <= '0;
      end else begin
         o_reg_write <= wb_req || !empty;
         if (wb_req) begin
            o_write_register <= i_wb_reg;
            o_write_data     <= i_wb_data;
         end else if (!empty) begin
            o_write_register <= head_reg;
            o_write_data     <= head_data;
         end
      end
   end
endmodule
